// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iteration datapath: shift-add multiply or restoring divide, one step per cycle.
module muldiv_core #(
  parameter int W = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_load,
  input  logic           i_load_div,
  input  logic           i_step,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_prod,
  output logic [W-1:0]   o_quot,
  output logic [W-1:0]   o_rem,
  output logic           o_mul_last
);

  logic           is_div;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   shreg;
  logic [W-1:0]   rem;
  logic [W-1:0]   divisor;

  logic [W:0]     trial;
  logic           fits;
  logic [W-1:0]   rem_next;

  // Trial remainder carries one extra bit so divisors above 2^(W-1) still compare correctly;
  // when it fits, the true difference is below 2^W so a W-bit subtract is exact.
  assign trial    = {rem, shreg[W-1]};
  assign fits     = (trial >= {1'b0, divisor});
  assign rem_next = fits ? (trial[W-1:0] - divisor) : trial[W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      is_div  <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      shreg   <= '0;
      rem     <= '0;
      divisor <= '0;
    end else if (i_load) begin
      is_div  <= i_load_div;
      acc     <= '0;
      mcand   <= {{W{1'b0}}, i_a};
      shreg   <= i_load_div ? i_a : i_b;
      rem     <= '0;
      divisor <= i_b;
    end else if (i_step) begin
      if (is_div) begin
        rem   <= rem_next;
        shreg <= {shreg[W-2:0], fits};
      end else begin
        if (shreg[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        shreg <= shreg >> 1;
      end
    end
  end

  assign o_prod     = acc;
  assign o_quot     = shreg;
  assign o_rem      = rem;
  // Multiplier has no set bits above the current LSB: this step is the last useful one.
  assign o_mul_last = ~|shreg[W-1:1];

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer with HI/LO commit and EX-stage stall.
// Build option: define MULDIV_EARLY_TERM_EN to end multiplies once the multiplier is exhausted.
//
// state   | meaning
// IDLE    | waiting for a mul/div in EX
// RUN     | one datapath iteration per cycle, pipeline stalled
// DONE    | sign-correct and commit HI/LO (or flag divide by zero)
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int INST_SZ = MD_ITER,
  parameter int MD_OP   = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start_E,
  input  logic [MD_OP-1:0]   i_md_op_E,
  input  logic [INST_SZ-1:0] i_operand_a_E,
  input  logic [INST_SZ-1:0] i_operand_b_E,
  input  logic               i_flush,
  output logic               o_stall_E,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_zero,
  output logic [INST_SZ-1:0] o_hi,
  output logic [INST_SZ-1:0] o_lo
);

  localparam int CNT_W = $clog2(INST_SZ);

`ifdef MULDIV_EARLY_TERM_EN
  localparam logic EARLY_TERM = 1'b1;
`else
  localparam logic EARLY_TERM = 1'b0;
`endif

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic               op_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero_q;

  logic               start_ok;
  logic               start_div;
  logic               start_sgn;
  logic               b_zero;
  logic               a_neg;
  logic               b_neg;
  logic [INST_SZ-1:0] a_mag;
  logic [INST_SZ-1:0] b_mag;
  logic               run_last;

  logic [2*INST_SZ-1:0] prod;
  logic [2*INST_SZ-1:0] prod_fix;
  logic [INST_SZ-1:0]   quot;
  logic [INST_SZ-1:0]   rem;
  logic [INST_SZ-1:0]   quot_fix;
  logic [INST_SZ-1:0]   rem_fix;
  logic                 mul_last;

  assign start_div = (i_md_op_E == MD_DIV) || (i_md_op_E == MD_DIVU);
  assign start_sgn = (i_md_op_E == MD_MULT) || (i_md_op_E == MD_DIV);
  assign start_ok  = (state == ST_IDLE) && i_start_E && !i_flush;
  assign b_zero    = (i_operand_b_E == '0);
  assign a_neg     = start_sgn & i_operand_a_E[INST_SZ-1];
  assign b_neg     = start_sgn & i_operand_b_E[INST_SZ-1];
  assign a_mag     = a_neg ? -i_operand_a_E : i_operand_a_E;
  assign b_mag     = b_neg ? -i_operand_b_E : i_operand_b_E;

  assign run_last  = (cnt == CNT_W'(INST_SZ - 1)) || (EARLY_TERM && !op_div && mul_last);

  muldiv_core #(.W(INST_SZ)) u_core (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (start_ok && !(start_div && b_zero)),
    .i_load_div (start_div),
    .i_step     ((state == ST_RUN) && !i_flush),
    .i_a        (a_mag),
    .i_b        (b_mag),
    .o_prod     (prod),
    .o_quot     (quot),
    .o_rem      (rem),
    .o_mul_last (mul_last)
  );

  assign prod_fix = neg_res ? -prod : prod;
  assign quot_fix = neg_res ? -quot : quot;
  assign rem_fix  = neg_rem ? -rem  : rem;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero_q <= 1'b0;
      o_hi       <= '0;
      o_lo       <= '0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            op_div     <= start_div;
            neg_res    <= a_neg ^ b_neg;
            neg_rem    <= a_neg;
            div_zero_q <= start_div && b_zero;
            cnt        <= '0;
            state      <= (start_div && b_zero) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_flush) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (run_last) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The op has already left EX, so a flush here does not cancel the commit.
          o_done     <= 1'b1;
          o_div_zero <= div_zero_q;
          if (!div_zero_q) begin
            if (op_div) begin
              o_lo <= quot_fix;
              o_hi <= rem_fix;
            end else begin
              {o_hi, o_lo} <= prod_fix;
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy    = (state != ST_IDLE);
  assign o_stall_E = ((state == ST_IDLE) && i_start_E) || (state == ST_RUN);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, HI/LO results, divide-by-zero, flush and reset.
module tb_muldiv_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start_E;
  logic [1:0]  i_md_op_E;
  logic [31:0] i_operand_a_E;
  logic [31:0] i_operand_b_E;
  logic        i_flush;
  logic        o_stall_E;
  logic        o_busy;
  logic        o_done;
  logic        o_div_zero;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int SMALL_MUL_STALL = 3;
`else
  localparam int SMALL_MUL_STALL = 33;
`endif

  always #5 i_clk = ~i_clk;

  muldiv_ctrl dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start_E     (i_start_E),
    .i_md_op_E     (i_md_op_E),
    .i_operand_a_E (i_operand_a_E),
    .i_operand_b_E (i_operand_b_E),
    .i_flush       (i_flush),
    .o_stall_E     (o_stall_E),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_zero    (o_div_zero),
    .o_hi          (o_hi),
    .o_lo          (o_lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and follow it to the o_done pulse, counting stalled cycles.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output logic done, output logic dz);
    int n;
    stalls = 0;
    done   = 1'b0;
    dz     = 1'b0;
    n      = 0;
    @(negedge i_clk);
    i_start_E     = 1'b1;
    i_md_op_E     = op;
    i_operand_a_E = a;
    i_operand_b_E = b;
    while (!done && n < 200) begin
      #1;
      if (o_stall_E) stalls++;
      @(negedge i_clk);
      i_start_E = 1'b0;
      if (o_done) begin
        done = 1'b1;
        dz   = o_div_zero;
      end
      n++;
    end
  endtask

  initial begin
    int   stalls;
    logic done;
    logic dz;
    int   n;

    i_reset       = 1'b0;
    i_start_E     = 1'b0;
    i_md_op_E     = 2'b00;
    i_operand_a_E = '0;
    i_operand_b_E = '0;
    i_flush       = 1'b0;

    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_hi",    64'(o_hi), 64'h0);
    chk("rst_lo",    64'(o_lo), 64'h0);
    chk("rst_busy",  64'(o_busy), 64'h0);
    chk("rst_done",  64'(o_done), 64'h0);
    chk("rst_dz",    64'(o_div_zero), 64'h0);
    chk("rst_stall", 64'(o_stall_E), 64'h0);
    i_reset = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, done, dz);
    chk("multu_stall", 64'(stalls), 64'd33);
    chk("multu_done",  64'(done), 64'h1);
    chk("multu_dz",    64'(dz), 64'h0);
    chk("multu_hi",    64'(o_hi), 64'hFFFF_FFFE);
    chk("multu_lo",    64'(o_lo), 64'h0000_0001);
    @(negedge i_clk);
    chk("done_pulse",  64'(o_done), 64'h0);

    run_op(2'b00, 32'hFFFF_FFF9, 32'd6, stalls, done, dz);
    chk("mult_done", 64'(done), 64'h1);
    chk("mult_hi",   64'(o_hi), 64'hFFFF_FFFF);
    chk("mult_lo",   64'(o_lo), 64'hFFFF_FFD6);

    run_op(2'b10, 32'hFFFF_FFEF, 32'd5, stalls, done, dz);
    chk("div_stall", 64'(stalls), 64'd33);
    chk("div_lo",    64'(o_lo), 64'hFFFF_FFFD);
    chk("div_hi",    64'(o_hi), 64'hFFFF_FFFE);

    run_op(2'b11, 32'd100, 32'd7, stalls, done, dz);
    chk("divu_lo", 64'(o_lo), 64'd14);
    chk("divu_hi", 64'(o_hi), 64'd2);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, stalls, done, dz);
    chk("ovf_lo", 64'(o_lo), 64'h8000_0000);
    chk("ovf_hi", 64'(o_hi), 64'h0);

    // 0x2211 / 0x100 leaves HI=0x11, LO=0x22 for the divide-by-zero step
    run_op(2'b11, 32'h0000_2211, 32'h0000_0100, stalls, done, dz);
    chk("pre_lo", 64'(o_lo), 64'h22);
    chk("pre_hi", 64'(o_hi), 64'h11);

    run_op(2'b11, 32'h1234_5678, 32'h0, stalls, done, dz);
    chk("dz_stall", 64'(stalls), 64'd1);
    chk("dz_done",  64'(done), 64'h1);
    chk("dz_flag",  64'(dz), 64'h1);
    chk("dz_hi",    64'(o_hi), 64'h11);
    chk("dz_lo",    64'(o_lo), 64'h22);

    // flush at RUN cycle 10
    @(negedge i_clk);
    i_start_E     = 1'b1;
    i_md_op_E     = 2'b01;
    i_operand_a_E = 32'd5;
    i_operand_b_E = 32'hFFFF_FFFF;
    @(negedge i_clk);
    i_start_E = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("flush_busy_pre", 64'(o_busy), 64'h1);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    #1;
    chk("flush_busy",  64'(o_busy), 64'h0);
    chk("flush_stall", 64'(o_stall_E), 64'h0);
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_done) done = 1'b1;
      @(negedge i_clk);
    end
    chk("flush_nodone", 64'(done), 64'h0);
    chk("flush_hi", 64'(o_hi), 64'h11);
    chk("flush_lo", 64'(o_lo), 64'h22);

    // reset mid-RUN discards the op and clears HI/LO
    @(negedge i_clk);
    i_start_E     = 1'b1;
    i_md_op_E     = 2'b01;
    i_operand_a_E = 32'd3;
    i_operand_b_E = 32'hFFFF_FFFF;
    @(negedge i_clk);
    i_start_E = 1'b0;
    repeat (5) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("mrst_hi",   64'(o_hi), 64'h0);
    chk("mrst_lo",   64'(o_lo), 64'h0);
    chk("mrst_busy", 64'(o_busy), 64'h0);
    i_reset = 1'b1;

    // flush together with start in IDLE: nothing starts
    @(negedge i_clk);
    i_start_E     = 1'b1;
    i_flush       = 1'b1;
    i_md_op_E     = 2'b01;
    i_operand_a_E = 32'd9;
    i_operand_b_E = 32'd9;
    @(negedge i_clk);
    i_start_E = 1'b0;
    i_flush   = 1'b0;
    #1;
    chk("flush_start_busy", 64'(o_busy), 64'h0);

    run_op(2'b01, 32'd12345, 32'd3, stalls, done, dz);
    chk("small_stall", 64'(stalls), 64'(SMALL_MUL_STALL));
    chk("small_lo",    64'(o_lo), 64'd37035);
    chk("small_hi",    64'(o_hi), 64'h0);

    // flush arriving in DONE must not block the commit
    @(negedge i_clk);
    i_start_E     = 1'b1;
    i_md_op_E     = 2'b11;
    i_operand_a_E = 32'd1000;
    i_operand_b_E = 32'd10;
    @(negedge i_clk);
    i_start_E = 1'b0;
    #1;
    n = 0;
    while (!(o_busy && !o_stall_E) && n < 100) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    chk("reach_done", 64'(n < 100), 64'h1);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("fdone_done", 64'(o_done), 64'h1);
    chk("fdone_lo",   64'(o_lo), 64'd100);
    chk("fdone_hi",   64'(o_hi), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
